// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: assembles the 2-bit RGBY-ROM colour stream into 12-bit
// words, validates the header, writes program words into RAM, verifies the
// trailing checksum and keeps the CPU halted until a clean load completes.
module rom_load_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        colorReady,
    input  logic [1:0]  color,
    input  logic [7:0]  cpuAddress,
    output logic        ramWriteEnable,
    output logic [7:0]  ramWriteAddress,
    output logic [11:0] ramWriteData,
    output logic [7:0]  ramReadAddress,
    output logic        cpuHalt,
    output logic        loadDone,
    output logic [1:0]  errorCode,
    output logic [8:0]  wordCount
);

    // The counter only ever holds 0..TIMEOUT_CYCLES-1; the terminal value is
    // detected one step early so the abort lands exactly TIMEOUT_CYCLES edges
    // after the last nit.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PROGRAM,
        S_CHECKSUM,
        S_DONE,
        S_ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_HEADER   = 2'd1,
        ERR_CHECKSUM = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_e;

    state_e        state_q,  state_d;
    logic [2:0]    nit_q,    nit_d;
    logic [11:0]   shift_q,  shift_d;
    logic [11:0]   acc_q,    acc_d;
    logic [TW-1:0] tmo_q,    tmo_d;
    logic [8:0]    wcnt_q,   wcnt_d;
    logic [8:0]    nwords_q, nwords_d;
    logic          halt_q,   halt_d;
    logic          done_q,   done_d;
    err_e          err_q,    err_d;
    logic          we_q,     we_d;
    logic [7:0]    wa_q,     wa_d;
    logic [11:0]   wd_q,     wd_d;

    logic          active;
    logic [11:0]   word;

    assign active = (state_q == S_HEADER) || (state_q == S_PROGRAM) ||
                    (state_q == S_CHECKSUM);
    // Word as it stands once the current nit is shifted in (MSB-first).
    assign word   = {shift_q[9:0], color};

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            nit_q    <= '0;
            shift_q  <= '0;
            acc_q    <= '0;
            tmo_q    <= '0;
            wcnt_q   <= '0;
            nwords_q <= '0;
            halt_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            nit_q    <= nit_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            tmo_q    <= tmo_d;
            wcnt_q   <= wcnt_d;
            nwords_q <= nwords_d;
            halt_q   <= halt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    // Next-state logic: start handling, nit assembly, word actions, timeout.
    always_comb begin
        // NOTE: every target gets a default first so no latch can be inferred.
        state_d  = state_q;
        nit_d    = nit_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        tmo_d    = tmo_q;
        wcnt_d   = wcnt_q;
        nwords_d = nwords_q;
        halt_d   = halt_q;
        done_d   = done_q;
        err_d    = err_q;
        we_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;

        if (!active) begin
            // start wins over any simultaneous colorReady; that nit is dropped.
            if (start) begin
                state_d = S_HEADER;
                nit_d   = '0;
                shift_d = '0;
                acc_d   = '0;
                tmo_d   = '0;
                wcnt_d  = '0;
                err_d   = ERR_NONE;
                done_d  = 1'b0;
                halt_d  = 1'b1;
            end
        end else if (colorReady) begin
            // A nit always beats the timeout terminal count.
            tmo_d   = '0;
            shift_d = word;
            if (nit_q == 3'd5) begin
                nit_d = '0;
                case (state_q)
                    S_HEADER: begin
                        if (word[11:8] == 4'hA) begin
                            nwords_d = (word[7:0] == 8'd0) ? 9'd256 : {1'b0, word[7:0]};
                            state_d  = S_PROGRAM;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = ERR_HEADER;
                        end
                    end
                    S_PROGRAM: begin
                        we_d   = 1'b1;
                        wa_d   = wcnt_q[7:0];
                        wd_d   = word;
                        acc_d  = acc_q + word;
                        wcnt_d = wcnt_q + 9'd1;
                        if (wcnt_q + 9'd1 == nwords_q) begin
                            state_d = S_CHECKSUM;
                        end
                    end
                    S_CHECKSUM: begin
                        if (word == acc_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            halt_d  = 1'b0;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = ERR_CHECKSUM;
                        end
                    end
                    default: ;
                endcase
            end else begin
                nit_d = nit_q + 3'd1;
            end
        end else if (tmo_q == TMO_LAST) begin
            state_d = S_ERROR;
            err_d   = ERR_TIMEOUT;
            nit_d   = '0;
            shift_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign ramWriteEnable  = we_q;
    assign ramWriteAddress = wa_q;
    assign ramWriteData    = wd_q;
    assign cpuHalt         = halt_q;
    assign loadDone        = done_q;
    assign errorCode       = err_q;
    assign wordCount       = wcnt_q;
    // The CPU sees address 0 while it is held, its own address otherwise.
    assign ramReadAddress  = halt_q ? 8'd0 : cpuAddress;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed testbench for rom_load_sequencer (TIMEOUT_CYCLES = 16).
module tb_rom_load_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        colorReady = 1'b0;
    logic [1:0]  color = 2'd0;
    logic [7:0]  cpuAddress = 8'd0;
    logic        ramWriteEnable;
    logic [7:0]  ramWriteAddress;
    logic [11:0] ramWriteData;
    logic [7:0]  ramReadAddress;
    logic        cpuHalt;
    logic        loadDone;
    logic [1:0]  errorCode;
    logic [8:0]  wordCount;

    int tests_run = 0;
    int fails = 0;

    // Write log filled by the monitor on the falling edge.
    int          cyc = 0;
    int          wr_n = 0;
    logic [7:0]  wr_addr [0:1023];
    logic [11:0] wr_data [0:1023];
    int          wr_cyc  [0:1023];

    rom_load_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .colorReady      (colorReady),
        .color           (color),
        .cpuAddress      (cpuAddress),
        .ramWriteEnable  (ramWriteEnable),
        .ramWriteAddress (ramWriteAddress),
        .ramWriteData    (ramWriteData),
        .ramReadAddress  (ramReadAddress),
        .cpuHalt         (cpuHalt),
        .loadDone        (loadDone),
        .errorCode       (errorCode),
        .wordCount       (wordCount)
    );

    always #5 clk = ~clk;

    // Record every cycle in which the write strobe is high.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ramWriteEnable) begin
            wr_addr[wr_n % 1024] <= ramWriteAddress;
            wr_data[wr_n % 1024] <= ramWriteData;
            wr_cyc[wr_n % 1024]  <= cyc;
            wr_n                 <= wr_n + 1;
        end
    end

    // Hard stop in case something wedges.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_nit(input logic [1:0] c);
        colorReady = 1'b1;
        color      = c;
        @(posedge clk);
        #1;
        colorReady = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] w);
        for (int i = 5; i >= 0; i--) send_nit(w[2*i +: 2]);
    endtask

    task automatic send_stream(input logic [11:0] csum);
        send_word(12'hA03);
        send_word(12'h123);
        send_word(12'h456);
        send_word(12'h789);
        send_word(csum);
    endtask

    task automatic test_reset();
        cpuAddress = 8'h77;
        reset = 1'b0;
        idle(3);
        tests_run++; if (cpuHalt !== 1'b1) begin fails++; $display("FAIL reset_halt: got %b expected 1", cpuHalt); end
        tests_run++; if (loadDone !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", loadDone); end
        tests_run++; if (errorCode !== 2'd0) begin fails++; $display("FAIL reset_err: got %0d expected 0", errorCode); end
        tests_run++; if (wordCount !== 9'd0) begin fails++; $display("FAIL reset_wc: got %0d expected 0", wordCount); end
        tests_run++; if (ramWriteEnable !== 1'b0) begin fails++; $display("FAIL reset_we: got %b expected 0", ramWriteEnable); end
        tests_run++; if (ramWriteAddress !== 8'd0) begin fails++; $display("FAIL reset_wa: got %h expected 00", ramWriteAddress); end
        tests_run++; if (ramWriteData !== 12'd0) begin fails++; $display("FAIL reset_wd: got %h expected 000", ramWriteData); end
        tests_run++; if (ramReadAddress !== 8'd0) begin fails++; $display("FAIL reset_ra: got %h expected 00", ramReadAddress); end
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_valid_load();
        int base;
        logic [11:0] exp_d [0:2];
        exp_d[0] = 12'h123; exp_d[1] = 12'h456; exp_d[2] = 12'h789;
        base = wr_n;
        cpuAddress = 8'h5A;
        do_start();
        send_word(12'hA03);
        send_word(12'h123);
        tests_run++; if (ramWriteEnable !== 1'b1) begin fails++; $display("FAIL valid_we0: got %b expected 1", ramWriteEnable); end
        tests_run++; if (ramWriteAddress !== 8'd0) begin fails++; $display("FAIL valid_wa0: got %h expected 00", ramWriteAddress); end
        tests_run++; if (ramWriteData !== 12'h123) begin fails++; $display("FAIL valid_wd0: got %h expected 123", ramWriteData); end
        tests_run++; if (wordCount !== 9'd1) begin fails++; $display("FAIL valid_wc1: got %0d expected 1", wordCount); end
        send_word(12'h456);
        send_word(12'h789);
        tests_run++; if (ramReadAddress !== 8'd0) begin fails++; $display("FAIL valid_ra_halted: got %h expected 00", ramReadAddress); end
        // five nits of the checksum: not complete yet
        for (int i = 5; i >= 1; i--) send_nit(2'(12'hD02 >> (2*i)));
        tests_run++; if (loadDone !== 1'b0) begin fails++; $display("FAIL valid_done_early: got %b expected 0", loadDone); end
        send_nit(2'b10);
        tests_run++; if (loadDone !== 1'b1) begin fails++; $display("FAIL valid_done: got %b expected 1", loadDone); end
        tests_run++; if (cpuHalt !== 1'b0) begin fails++; $display("FAIL valid_halt: got %b expected 0", cpuHalt); end
        tests_run++; if (errorCode !== 2'd0) begin fails++; $display("FAIL valid_err: got %0d expected 0", errorCode); end
        tests_run++; if (wordCount !== 9'd3) begin fails++; $display("FAIL valid_wc: got %0d expected 3", wordCount); end
        tests_run++; if (ramReadAddress !== 8'h5A) begin fails++; $display("FAIL valid_ra: got %h expected 5a", ramReadAddress); end
        cpuAddress = 8'hC3;
        #1;
        tests_run++; if (ramReadAddress !== 8'hC3) begin fails++; $display("FAIL valid_ra2: got %h expected c3", ramReadAddress); end
        idle(2);
        tests_run++; if (wr_n - base !== 3) begin fails++; $display("FAIL valid_nwrites: got %0d expected 3", wr_n - base); end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (wr_addr[(base+i)%1024] !== 8'(i)) begin fails++; $display("FAIL valid_log_addr[%0d]: got %h expected %h", i, wr_addr[(base+i)%1024], i); end
            tests_run++; if (wr_data[(base+i)%1024] !== exp_d[i]) begin fails++; $display("FAIL valid_log_data[%0d]: got %h expected %h", i, wr_data[(base+i)%1024], exp_d[i]); end
            if (i > 0) begin
                tests_run++; if (wr_cyc[(base+i)%1024] - wr_cyc[(base+i-1)%1024] !== 6) begin fails++; $display("FAIL valid_log_gap[%0d]: got %0d expected 6", i, wr_cyc[(base+i)%1024] - wr_cyc[(base+i-1)%1024]); end
            end
        end
    endtask

    task automatic test_bad_checksum();
        int base;
        base = wr_n;
        cpuAddress = 8'h5A;
        do_start();
        send_stream(12'hD03);
        tests_run++; if (errorCode !== 2'd2) begin fails++; $display("FAIL csum_err: got %0d expected 2", errorCode); end
        tests_run++; if (loadDone !== 1'b0) begin fails++; $display("FAIL csum_done: got %b expected 0", loadDone); end
        tests_run++; if (cpuHalt !== 1'b1) begin fails++; $display("FAIL csum_halt: got %b expected 1", cpuHalt); end
        tests_run++; if (ramReadAddress !== 8'd0) begin fails++; $display("FAIL csum_ra: got %h expected 00", ramReadAddress); end
        tests_run++; if (wordCount !== 9'd3) begin fails++; $display("FAIL csum_wc: got %0d expected 3", wordCount); end
        idle(2);
        tests_run++; if (wr_n - base !== 3) begin fails++; $display("FAIL csum_nwrites: got %0d expected 3", wr_n - base); end
    endtask

    task automatic test_bad_header();
        int base;
        base = wr_n;
        do_start();
        send_word(12'h503);
        tests_run++; if (errorCode !== 2'd1) begin fails++; $display("FAIL hdr_err: got %0d expected 1", errorCode); end
        tests_run++; if (cpuHalt !== 1'b1) begin fails++; $display("FAIL hdr_halt: got %b expected 1", cpuHalt); end
        // colour traffic in ERROR is ignored
        send_word(12'h123);
        idle(2);
        tests_run++; if (wr_n - base !== 0) begin fails++; $display("FAIL hdr_nwrites: got %0d expected 0", wr_n - base); end
        tests_run++; if (errorCode !== 2'd1) begin fails++; $display("FAIL hdr_err_hold: got %0d expected 1", errorCode); end
        // start with a coincident nit: the nit must be dropped
        start = 1'b1; colorReady = 1'b1; color = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0; colorReady = 1'b0;
        tests_run++; if (errorCode !== 2'd0) begin fails++; $display("FAIL hdr_restart_err: got %0d expected 0", errorCode); end
        send_stream(12'hD02);
        tests_run++; if (loadDone !== 1'b1) begin fails++; $display("FAIL hdr_restart_done: got %b expected 1", loadDone); end
        tests_run++; if (errorCode !== 2'd0) begin fails++; $display("FAIL hdr_restart_err2: got %0d expected 0", errorCode); end
        idle(2);
        tests_run++; if (wr_n - base !== 3) begin fails++; $display("FAIL hdr_restart_nwrites: got %0d expected 3", wr_n - base); end
    endtask

    task automatic test_timeout();
        int base;
        base = wr_n;
        do_start();
        send_nit(2'd2);
        send_nit(2'd2);
        send_nit(2'd0);
        repeat (15) @(posedge clk);
        #1;
        tests_run++; if (errorCode !== 2'd0) begin fails++; $display("FAIL tmo_early: got %0d expected 0", errorCode); end
        @(posedge clk);
        #1;
        tests_run++; if (errorCode !== 2'd3) begin fails++; $display("FAIL tmo_err: got %0d expected 3", errorCode); end
        tests_run++; if (cpuHalt !== 1'b1) begin fails++; $display("FAIL tmo_halt: got %b expected 1", cpuHalt); end
        send_word(12'hA03);
        send_word(12'h123);
        idle(2);
        tests_run++; if (errorCode !== 2'd3) begin fails++; $display("FAIL tmo_err_hold: got %0d expected 3", errorCode); end
        tests_run++; if (wordCount !== 9'd0) begin fails++; $display("FAIL tmo_wc: got %0d expected 0", wordCount); end
        tests_run++; if (wr_n - base !== 0) begin fails++; $display("FAIL tmo_nwrites: got %0d expected 0", wr_n - base); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = wr_n;
        do_start();
        send_word(12'hA00);
        for (int i = 0; i < 256; i++) send_word(12'hFFF);
        send_word(12'hF00);
        tests_run++; if (loadDone !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b expected 1", loadDone); end
        tests_run++; if (errorCode !== 2'd0) begin fails++; $display("FAIL b2b_err: got %0d expected 0", errorCode); end
        tests_run++; if (wordCount !== 9'd256) begin fails++; $display("FAIL b2b_wc: got %0d expected 256", wordCount); end
        idle(2);
        tests_run++; if (wr_n - base !== 256) begin fails++; $display("FAIL b2b_nwrites: got %0d expected 256", wr_n - base); end
        for (int i = 0; i < 256; i++) begin
            tests_run++; if (wr_addr[(base+i)%1024] !== 8'(i)) begin fails++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, wr_addr[(base+i)%1024], i); end
            tests_run++; if (wr_data[(base+i)%1024] !== 12'hFFF) begin fails++; $display("FAIL b2b_data[%0d]: got %h expected fff", i, wr_data[(base+i)%1024]); end
            if (i > 0) begin
                tests_run++; if (wr_cyc[(base+i)%1024] - wr_cyc[(base+i-1)%1024] !== 6) begin fails++; $display("FAIL b2b_gap[%0d]: got %0d expected 6", i, wr_cyc[(base+i)%1024] - wr_cyc[(base+i-1)%1024]); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        base = wr_n;
        do_start();
        send_word(12'hA03);
        send_word(12'h111);
        send_word(12'h222);
        send_nit(2'd1);
        send_nit(2'd2);
        send_nit(2'd3);
        reset = 1'b0;
        #1;
        tests_run++; if (cpuHalt !== 1'b1) begin fails++; $display("FAIL rst_halt: got %b expected 1", cpuHalt); end
        tests_run++; if (wordCount !== 9'd0) begin fails++; $display("FAIL rst_wc: got %0d expected 0", wordCount); end
        tests_run++; if (ramWriteAddress !== 8'd0) begin fails++; $display("FAIL rst_wa: got %h expected 00", ramWriteAddress); end
        tests_run++; if (ramWriteData !== 12'd0) begin fails++; $display("FAIL rst_wd: got %h expected 000", ramWriteData); end
        tests_run++; if (errorCode !== 2'd0) begin fails++; $display("FAIL rst_err: got %0d expected 0", errorCode); end
        send_nit(2'd0);
        send_nit(2'd1);
        send_nit(2'd2);
        reset = 1'b1;
        send_word(12'h333);
        idle(4);
        tests_run++; if (wr_n - base !== 2) begin fails++; $display("FAIL rst_nwrites: got %0d expected 2", wr_n - base); end
        tests_run++; if (wordCount !== 9'd0) begin fails++; $display("FAIL rst_idle_wc: got %0d expected 0", wordCount); end
        do_start();
        send_stream(12'hD02);
        tests_run++; if (loadDone !== 1'b1) begin fails++; $display("FAIL rst_reload_done: got %b expected 1", loadDone); end
        tests_run++; if (wordCount !== 9'd3) begin fails++; $display("FAIL rst_reload_wc: got %0d expected 3", wordCount); end
        idle(2);
        tests_run++; if (wr_n - base !== 5) begin fails++; $display("FAIL rst_reload_nwrites: got %0d expected 5", wr_n - base); end
        tests_run++; if (wr_addr[(base+2)%1024] !== 8'd0) begin fails++; $display("FAIL rst_reload_addr: got %h expected 00", wr_addr[(base+2)%1024]); end
    endtask

    initial begin
        test_reset();
        test_valid_load();
        test_bad_checksum();
        test_bad_header();
        test_timeout();
        test_back_to_back();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Sequences loading a program from the RGBY-ROM data cartridge into program RAM and gates CPU access to that RAM. It assembles the 2-bit colour stream into 12-bit words and validates a header word. It writes the program words to RAM, checks a trailing checksum and holds the CPU halted until a load completes cleanly. It sits between the cartridge colour decoder and the RAM's write and read ports.

## Interface
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between colour nits while loading before abort (≥2).
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle load request.
- colorReady  in  1  single-cycle strobe marking `color` valid; may be back-to-back.
- color  in  2  colour nit.
- cpuAddress  in  8  CPU program-fetch address.
- ramWriteEnable  out  1  one-cycle RAM write strobe.
- ramWriteAddress  out  8  RAM write address.
- ramWriteData  out  12  RAM write data.
- ramReadAddress  out  8  RAM read address.
- cpuHalt  out  1  1 = CPU held.
- loadDone  out  1  1 = valid program resident.
- errorCode  out  2  0 none, 1 bad header, 2 checksum mismatch, 3 timeout.
- wordCount  out  9  program words written in the current or last load.

## Operation
- States: IDLE, HEADER, PROGRAM, CHECKSUM, DONE, ERROR.
- Reset values:
  - state IDLE; cpuHalt=1; loadDone=0; errorCode=0; wordCount=0.
  - ramWriteEnable=0, ramWriteAddress=0, ramWriteData=0.
  - Nit counter, shift register, checksum accumulator and timeout counter all 0.
- `start` in IDLE, DONE or ERROR:
  - Go to HEADER.
  - Clear the nit counter, accumulator, wordCount, errorCode, loadDone and timeout counter.
  - Set cpuHalt=1.
  - `start` in HEADER, PROGRAM or CHECKSUM is ignored.
- Nit assembly (HEADER, PROGRAM and CHECKSUM only):
  - Each colorReady shifts `color` in MSB-first; the first nit of a word lands in bits [11:10].
  - The 6th nit completes the word and clears the nit counter.
  - colorReady is ignored in IDLE, DONE and ERROR.
- HEADER word: bits [11:8] must equal 4'hA; bits [7:0] = N program words, with N=0 meaning 256.
  - Bad magic → ERROR, errorCode=1, no RAM write.
  - Otherwise latch N and go to PROGRAM.
- PROGRAM word:
  - Write the word to address wordCount[7:0].
  - Accumulator += word, mod 4096 (12-bit wrap).
  - wordCount += 1.
  - When wordCount reaches N, go to CHECKSUM.
- CHECKSUM word:
  - Equals the accumulator → DONE: loadDone=1, cpuHalt=0.
  - Otherwise → ERROR, errorCode=2. Program RAM contents are left as written.
- Timeout:
  - In HEADER, PROGRAM and CHECKSUM the timeout counter increments every cycle without colorReady and clears on colorReady.
  - Reaching TIMEOUT_CYCLES → ERROR, errorCode=3, partial nit discarded.
- ramReadAddress = cpuAddress when cpuHalt=0, else 0 (combinational).
- DONE and ERROR hold until `start` or reset.

## Timing
- Word completes on the colorReady at edge t.
  - At t+1: ramWriteEnable=1 for exactly one cycle, with ramWriteAddress and ramWriteData valid (PROGRAM words only).
  - At t+1: the state transition, wordCount update, loadDone/cpuHalt/errorCode update.
- Back-to-back colorReady at full clock rate is sustained with no lost nits; a 6-nit word every 6 cycles gives one write pulse every 6 cycles.
- Timeout fires at the edge where the counter equals TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after the last colorReady or after `start`.
- Simultaneous colorReady and timeout terminal count: colorReady wins and the counter clears.
- Simultaneous `start` and colorReady in IDLE/DONE/ERROR: `start` is taken and the nit is discarded.
- ramWriteAddress wraps 255→0 never occurs; at most 256 writes, to addresses 0..255.
- Reset asserted mid-load: all outputs return to reset values immediately (asynchronous). A partial word is not written.

## Test plan
- Valid load: start; header 0xA03; words 0x123, 0x456, 0x789; checksum 0xD02 → writes (0,0x123), (1,0x456), (2,0x789), one-cycle pulses each; wordCount=3; loadDone=1, cpuHalt=0 one cycle after the checksum's 6th nit; ramReadAddress follows cpuAddress.
- Same stream with checksum 0xD03 → three writes occur; errorCode=2; loadDone=0; cpuHalt=1; ramReadAddress=0.
- Header 0x503 → ERROR, errorCode=1, no ramWriteEnable pulse; a subsequent start with a valid stream ends in DONE.
- TIMEOUT_CYCLES=16: start, send 3 nits, then stop → errorCode=3 exactly 16 cycles after the 3rd nit; no write; colorReady afterwards ignored.
- Header 0xA00 with colorReady every cycle, 256 words of 0xFFF, checksum 0xF00 (256×0xFFF mod 4096) → 256 writes to addresses 0..255, one every 6 cycles; wordCount=256; DONE.
- Reset pulse during PROGRAM after 2 writes → outputs at reset values immediately, no further writes; a new start plus the valid stream loads cleanly to DONE.
